// File: rtl/dct8_pkg.sv
// Shared constants and types for the streaming 8-point DCT-II core.
// Coefficients are orthonormal DCT-II basis values in signed Q1.15.
package dct8_pkg;

    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 15;
    localparam int ROUND_K   = 1 << (COEF_FRAC - 1);

    typedef enum logic [1:0] {
        LOAD,
        MAC,
        EMIT
    } state_e;

    typedef logic signed [COEF_W-1:0] coef_t;

    // 16384 * cos(m*pi/16); a_0 * 32768 rounds to the same value as C4
    localparam coef_t C1 = 16'sd16069;
    localparam coef_t C2 = 16'sd15137;
    localparam coef_t C3 = 16'sd13623;
    localparam coef_t C4 = 16'sd11585;
    localparam coef_t C5 = 16'sd9102;
    localparam coef_t C6 = 16'sd6270;
    localparam coef_t C7 = 16'sd3196;

    localparam coef_t COEF_TBL [8][8] = '{
        '{ C4,  C4,  C4,  C4,  C4,  C4,  C4,  C4},
        '{ C1,  C3,  C5,  C7, -C7, -C5, -C3, -C1},
        '{ C2,  C6, -C6, -C2, -C2, -C6,  C6,  C2},
        '{ C3, -C7, -C1, -C5,  C5,  C1,  C7, -C3},
        '{ C4, -C4, -C4,  C4,  C4, -C4, -C4,  C4},
        '{ C5, -C1,  C7,  C3, -C3, -C7,  C1, -C5},
        '{ C6, -C2,  C2, -C6, -C6,  C2, -C2,  C6},
        '{ C7, -C5,  C3, -C1,  C1, -C3,  C5, -C7}
    };

endpackage

// File: rtl/dct8_fix2int.sv
// Q.15 accumulator to OUT_W integer: optional half-up rounding,
// then either saturation or two's-complement wrap.
module dct8_fix2int #(
    parameter int ACC_W    = 27,
    parameter int OUT_W    = 12,
    parameter int ROUND_EN = 1,
    parameter int SAT_EN   = 1
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] int_o
);
    import dct8_pkg::*;

    localparam int RW = ACC_W + 1;
    localparam int WW = ((RW > OUT_W) ? RW : OUT_W) + 1;

    localparam logic signed [WW-1:0] MAX_V =
        {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_V =
        {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] shifted;
    logic signed [WW-1:0] wide;

    // One guard bit keeps the rounding add from overflowing
    always_comb begin
        biased = {acc_i[ACC_W-1], acc_i};
        if (ROUND_EN != 0) begin
            biased = biased + RW'(ROUND_K);
        end
        shifted = biased >>> COEF_FRAC;
        wide    = {{(WW-RW){shifted[RW-1]}}, shifted};
        int_o   = wide[OUT_W-1:0];
        if (SAT_EN != 0) begin
            if (wide > MAX_V) begin
                int_o = MAX_V[OUT_W-1:0];
            end else if (wide < MIN_V) begin
                int_o = MIN_V[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dct8_stream_core.sv
// Streaming 8-point DCT-II: load eight samples, one shared MAC,
// serial coefficient output with valid/ready backpressure.
module dct8_stream_core #(
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 12,
    parameter int ROUND_EN = 1,
    parameter int SAT_EN   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [2:0]               out_idx,
    output logic                     out_last,
    input  logic                     out_ready
);
    import dct8_pkg::*;

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + 19;

    state_e state_q, state_d;

    logic [2:0] n_q, n_d;
    logic [2:0] k_q, k_d;

    logic signed [DATA_W-1:0] buf_q [8];

    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic [2:0]              out_idx_q, out_idx_d;
    logic                    out_last_q, out_last_d;

    logic [2:0]               mk;
    logic [2:0]               mn;
    coef_t                    coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [OUT_W-1:0]  fix_w;
    logic                     emit_hs;

    // An accepted X[k] handshake doubles as the n=0 MAC step of k+1
    assign mk = (state_q == EMIT) ? k_q + 3'd1 : k_q;
    assign mn = (state_q == EMIT) ? 3'd0 : n_q;

    assign coef   = COEF_TBL[mk][mn];
    assign prod   = buf_q[mn] * coef;
    assign prod_x = ACC_W'(prod);

    assign emit_hs = out_valid_q && out_ready;

    dct8_fix2int #(
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .ROUND_EN (ROUND_EN),
        .SAT_EN   (SAT_EN)
    ) u_fix2int (
        .acc_i (acc_q),
        .int_o (fix_w)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    n_d = n_q + 3'd1;
                    if (n_q == 3'd7) begin
                        state_d = MAC;
                        n_d     = 3'd0;
                        k_d     = 3'd0;
                    end
                end
            end
            MAC: begin
                acc_d = (n_q == 3'd0) ? prod_x : acc_q + prod_x;
                n_d   = n_q + 3'd1;
                if (n_q == 3'd7) begin
                    state_d = EMIT;
                    n_d     = 3'd0;
                end
            end
            EMIT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = fix_w;
                    out_idx_d   = k_q;
                    out_last_d  = (k_q == 3'd7);
                end else if (emit_hs) begin
                    out_valid_d = 1'b0;
                    if (k_q == 3'd7) begin
                        state_d = LOAD;
                        n_d     = 3'd0;
                        k_d     = 3'd0;
                    end else begin
                        state_d = MAC;
                        k_d     = k_q + 3'd1;
                        acc_d   = prod_x;
                        n_d     = 3'd1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            n_q         <= 3'd0;
            k_q         <= 3'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            buf_q[n_q] <= in_data;
        end
    end

    assign in_ready  = (state_q == LOAD) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct8_stream_core.sv
// Directed and randomised-backpressure checks of dct8_stream_core,
// four parameterisations driven by one shared stimulus stream.
module tb_dct8_stream_core;

    localparam real PI = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_data = '0;
    logic              out_ready = 1'b0;

    logic              rdy0, rdyT, rdyS, rdyW;
    logic              ov0, ovT, ovS, ovW;
    logic signed [11:0] od0, odT;
    logic signed [7:0]  odS, odW;
    logic [2:0]        oi0, oiT, oiS, oiW;
    logic              ol0, olT, olS, olW;

    dct8_stream_core u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .out_valid(ov0),
        .out_data(od0), .out_idx(oi0),
        .out_last(ol0), .out_ready(out_ready)
    );

    dct8_stream_core #(.ROUND_EN(0)) u_trn (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdyT), .out_valid(ovT),
        .out_data(odT), .out_idx(oiT),
        .out_last(olT), .out_ready(out_ready)
    );

    dct8_stream_core #(.OUT_W(8)) u_sat8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdyS), .out_valid(ovS),
        .out_data(odS), .out_idx(oiS),
        .out_last(olS), .out_ready(out_ready)
    );

    dct8_stream_core #(.OUT_W(8), .SAT_EN(0)) u_wrp8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdyW), .out_valid(ovW),
        .out_data(odW), .out_idx(oiW),
        .out_last(olW), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;
    int t_acc;
    int t_seen;
    int bad_rdy;

    longint g0 [8];
    longint gT [8];
    longint gS [8];
    longint gW [8];

    task automatic check(input string tag,
                         input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_coef(input int s[8], input int k,
                                        input int w, input bit rnd,
                                        input bit sat);
        longint acc, r, q, lim;
        real a;
        acc = 0;
        a = (k == 0) ? $sqrt(0.125) : 0.5;
        for (int n = 0; n < 8; n++) begin
            q = longint'(a * $cos(PI * real'((2 * n + 1) * k) / 16.0)
                         * 32768.0);
            acc += longint'(s[n]) * q;
        end
        r = rnd ? (acc + 16384) >>> 15 : acc >>> 15;
        lim = longint'(1) << (w - 1);
        if (sat) begin
            if (r > lim - 1) r = lim - 1;
            else if (r < -lim) r = -lim;
        end else begin
            r = r & ((lim << 1) - 1);
            if (r >= lim) r -= lim << 1;
        end
        return r;
    endfunction

    task automatic send_block(input int s[8], input int gap);
        int guard;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(s[i]);
            guard = 0;
            while (!rdy0 && guard < 200) begin
                @(posedge clk); #1;
                guard++;
            end
            check($sformatf("load_ready[%0d]", i), rdy0, 1);
            @(posedge clk); #1;
            t_acc    = cyc;
            in_valid = 1'b0;
            if (i < 7) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic get_coef(input int k, input bit rnd);
        int guard;
        bit seen;
        bit stalled;
        logic signed [11:0] held;
        guard = 0;
        seen = 0;
        stalled = 0;
        held = '0;
        if (k == 7) in_valid = 1'b0;
        while (1) begin
            if (rdy0) bad_rdy++;
            if (ov0) begin
                if (!seen) begin
                    seen = 1;
                    t_seen = cyc;
                end
                if (stalled) check($sformatf("stable[%0d]", k), od0, held);
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) begin
                    check($sformatf("idx[%0d]", k), oi0, k);
                    check($sformatf("last[%0d]", k), ol0, k == 7);
                    g0[k] = od0;
                    gT[k] = odT;
                    gS[k] = odS;
                    gW[k] = odW;
                    @(posedge clk); #1;
                    out_ready = 1'b0;
                    return;
                end
                held = od0;
                stalled = 1;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 300) begin
                check($sformatf("coef_timeout[%0d]", k), 0, 1);
                return;
            end
        end
    endtask

    task automatic run_block(input int s[8], input int gap,
                             input bit rnd, input bit junk);
        int lat;
        lat = 0;
        send_block(s, gap);
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'sh55;
        end
        bad_rdy = 0;
        for (int k = 0; k < 8; k++) begin
            get_coef(k, rnd);
            if (k == 0) lat = t_seen + 1 - t_acc;
        end
        check("in_ready_low", bad_rdy, 0);
        check("first_valid_edge", lat, 10);
        check("in_ready_back", rdy0, 1);
    endtask

    task automatic cmp8(input string tag, input longint g[8],
                        input longint e[8]);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s[%0d]", tag, k), g[k], e[k]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int blk [8];
        int imp [8];
        longint e_imp [8];
        longint e [8];
        int guard;

        imp   = '{64, 0, 0, 0, 0, 0, 0, 0};
        e_imp = '{23, 31, 30, 27, 23, 18, 12, 6};

        #1;
        check("rst_in_ready", rdy0, 0);
        @(posedge clk); #1;
        check("rst_out_valid", ov0, 0);
        check("rst_out_data", od0, 0);
        check("rst_out_idx", oi0, 0);
        check("rst_out_last", ol0, 0);
        check("rst_in_ready_hold", rdy0, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", rdy0, 1);

        blk = '{100, 100, 100, 100, 100, 100, 100, 100};
        run_block(blk, 0, 0, 0);
        e = '{283, 0, 0, 0, 0, 0, 0, 0};
        cmp8("const_rnd", g0, e);
        e = '{282, 0, 0, 0, 0, 0, 0, 0};
        cmp8("const_trunc", gT, e);

        run_block(imp, 0, 0, 1);
        cmp8("impulse", g0, e_imp);

        blk = '{127, 127, 127, 127, 127, 127, 127, 127};
        run_block(blk, 0, 0, 0);
        check("max_w12", g0[0], 359);
        check("max_sat8", gS[0], 127);
        check("max_wrap8", gW[0], 103);
        check("max_x1", g0[1], 0);

        run_block(imp, 1, 0, 0);
        cmp8("impulse_gap", g0, e_imp);

        send_block(imp, 0);
        for (int k = 0; k < 3; k++) get_coef(k, 0);
        guard = 0;
        while (!ov0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("x3_valid", ov0, 1);
        check("x3_idx", oi0, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_emit_valid", ov0, 0);
        check("rst_emit_ready", rdy0, 1);
        run_block(imp, 0, 0, 0);
        cmp8("impulse_after_rst", g0, e_imp);

        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 8; i++) begin
                blk[i] = int'($urandom_range(0, 255)) - 128;
            end
            run_block(blk, 0, 1, 0);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("rand%0d_x%0d", b, k),
                      g0[k], ref_coef(blk, k, 12, 1, 1));
                check($sformatf("rand%0d_trn%0d", b, k),
                      gT[k], ref_coef(blk, k, 12, 0, 1));
                check($sformatf("rand%0d_sat%0d", b, k),
                      gS[k], ref_coef(blk, k, 8, 1, 1));
                check($sformatf("rand%0d_wrp%0d", b, k),
                      gW[k], ref_coef(blk, k, 8, 1, 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
